// File: rtl/conv1_feeder.sv
// conv1_feeder: streams one WIDTH x IMG_HEIGHT image from a synchronous-read
// memory as a gap-free WIDTH x HEIGHT word stream. Rows IMG_HEIGHT..HEIGHT-1
// are emitted as zero padding.
// Data path: issue (mem_addr/mem_en) -> stage 1 (flags) -> stage 2 (output).
module conv1_feeder #(
  parameter int WIDTH      = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int HEIGHT     = 36,
  parameter int DATA_BITS  = 32,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_en,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 sof,
  output logic                 eof,
  output logic                 busy,
  output logic                 done
);

  // Counter widths hold one past the last index so the row increment never wraps.
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] IMG_ROWS = RW'(IMG_HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Control / issue registers
  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 flush_q, flush_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Stage 1: flags for the index whose memory read is in flight
  logic s1_valid_q, s1_valid_d;
  logic s1_pad_q, s1_pad_d;
  logic s1_first_q, s1_first_d;
  logic s1_last_q, s1_last_d;

  // Stage 2: output word and framing
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;

  // Helper terms for the current index
  logic          is_last_s;
  logic          col_wrap_s;
  logic [RW-1:0] row_nxt_s;

  // FSM next-state, index counters, address generation and stage-1 flags
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    flush_d    = flush_q;
    addr_d     = addr_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    s1_valid_d = 1'b0;
    s1_pad_d   = 1'b0;
    s1_first_d = 1'b0;
    s1_last_d  = 1'b0;

    col_wrap_s = (col_q == COL_LAST);
    is_last_s  = (row_q == ROW_LAST) && col_wrap_s;
    if (col_wrap_s) begin
      row_nxt_s = row_q + RW'(1);
    end else begin
      row_nxt_s = row_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Index 0 is issued on the very edge that accepts start.
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          flush_d = 1'b0;
          addr_d  = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          en_d = 1'b0;
        end
      end
      S_RUN: begin
        s1_valid_d = 1'b1;
        s1_pad_d   = (row_q >= IMG_ROWS);
        s1_first_d = (row_q == '0) && (col_q == '0);
        s1_last_d  = is_last_s;
        if (is_last_s) begin
          state_d = S_FLUSH;
          flush_d = 1'b0;
          en_d    = 1'b0;
        end else begin
          if (col_wrap_s) begin
            col_d = '0;
          end else begin
            col_d = col_q + CW'(1);
          end
          row_d = row_nxt_s;
          // Image words are contiguous row-major, so the next address is +1.
          if (row_nxt_s < IMG_ROWS) begin
            en_d   = 1'b1;
            addr_d = addr_q + ADDR_BITS'(1);
          end else begin
            en_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        // Two cycles let the last word pass through both pipeline stages.
        if (flush_q) begin
          state_d = S_IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        flush_d = 1'b0;
      end
    endcase
  end

  // Stage 2: select memory data or zero padding and forward framing flags
  always_comb begin
    data_d  = '0;
    valid_d = s1_valid_q;
    sof_d   = s1_valid_q & s1_first_q;
    eof_d   = s1_valid_q & s1_last_q;
    if (s1_valid_q && !s1_pad_q) begin
      data_d = mem_rdata;
    end else begin
      data_d = '0;
    end
  end

  // State, counter and issue registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      flush_q <= 1'b0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      flush_q <= flush_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Pipeline stage 1 and stage 2 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pad_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pad_q   <= s1_pad_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_en    = en_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
